// File: rtl/vga_platform_renderer.sv
// VGA timing generator, pixel-clock divider and N-platform renderer with
// per-platform holes that scroll horizontally once per frame (wrap-around).
// Adjacent platforms scroll in opposite directions; dir swaps the pairing.
module vga_platform_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int N_PLAT     = 4,
  parameter int PLAT_Y0    = 100,
  parameter int PLAT_PITCH = 96,
  parameter int PLAT_H     = 16,
  parameter int HOLE_W     = 64,
  parameter int HOLE_STEP  = 2,
  parameter logic [2:0] COLOR_BG   = 3'b001,
  parameter logic [2:0] COLOR_PLAT = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scroll_en,
  input  logic       dir,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_tick
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLE_GAP = H_ACTIVE / N_PLAT;

  // True when pixel x lies in the hole starting at hx; the hole may wrap
  // past the right edge and continue from x=0.
  function automatic logic in_hole(input logic [9:0] x, input logic [9:0] hx);
    logic [10:0] x_w, hx_w, hend;
    x_w  = {1'b0, x};
    hx_w = {1'b0, hx};
    hend = hx_w + 11'(HOLE_W);
    if (hend <= 11'(H_ACTIVE))
      in_hole = (x_w >= hx_w) && (x_w < hend);
    else
      in_hole = (x_w >= hx_w) || (x_w < hend - 11'(H_ACTIVE));
  endfunction

  // True when line y is one of platform i's rows.
  function automatic logic in_rows(input logic [9:0] y, input int i);
    int top;
    top     = PLAT_Y0 + i * PLAT_PITCH;
    in_rows = (int'(y) >= top) && (int'(y) < top + PLAT_H);
  endfunction

  // Hole moved right by one step, wrapped back into [0, H_ACTIVE).
  function automatic logic [9:0] step_right(input logic [9:0] hx);
    logic [10:0] s;
    s = {1'b0, hx} + 11'(HOLE_STEP);
    if (s >= 11'(H_ACTIVE)) s = s - 11'(H_ACTIVE);
    step_right = 10'(s);
  endfunction

  // Hole moved left by one step, wrapped back into [0, H_ACTIVE).
  function automatic logic [9:0] step_left(input logic [9:0] hx);
    logic [10:0] s;
    if ({1'b0, hx} < 11'(HOLE_STEP))
      s = {1'b0, hx} + 11'(H_ACTIVE) - 11'(HOLE_STEP);
    else
      s = {1'b0, hx} - 11'(HOLE_STEP);
    step_left = 10'(s);
  endfunction

  // ---- stage p0: pixel enable, raster counters, hole positions ----
  logic [DIV_W-1:0] div_p0;
  logic [9:0]       h_p0, v_p0;
  logic [9:0]       hole_x [N_PLAT];
  logic             pe, h_last, v_last, plat_hit, active;

  assign pe         = (div_p0 == DIV_W'(CLK_DIV - 1));
  assign h_last     = (h_p0 == 10'(H_TOTAL - 1));
  assign v_last     = (v_p0 == 10'(V_TOTAL - 1));
  assign frame_tick = pe && h_last && (v_p0 == 10'(V_ACTIVE - 1));
  assign active     = (h_p0 < 10'(H_ACTIVE)) && (v_p0 < 10'(V_ACTIVE));

  // Divide clk down to the pixel rate; with CLK_DIV=1 the count stays 0 and pe stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  div_p0 <= '0;
    else if (pe) div_p0 <= '0;
    else         div_p0 <= div_p0 + 1'b1;
  end

  // Raster scan: h advances per pixel, v advances when h wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (pe) begin
      if (h_last) begin
        h_p0 <= '0;
        v_p0 <= v_last ? 10'd0 : v_p0 + 10'd1;
      end else begin
        h_p0 <= h_p0 + 10'd1;
      end
    end
  end

  // Move every hole once per frame at the start of vertical blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PLAT; i++) hole_x[i] <= 10'(i * HOLE_GAP);
    end else if (frame_tick && scroll_en) begin
      for (int i = 0; i < N_PLAT; i++) begin
        if ((i % 2 == 0) != dir) hole_x[i] <= step_right(hole_x[i]);
        else                     hole_x[i] <= step_left(hole_x[i]);
      end
    end
  end

  // Platform hit test for the current raster position.
  always_comb begin
    plat_hit = 1'b0;
    for (int i = 0; i < N_PLAT; i++)
      if (in_rows(v_p0, i) && !in_hole(h_p0, hole_x[i])) plat_hit = 1'b1;
  end

  // ---- stage p1: registered, mutually aligned VGA outputs ----
  logic [2:0] rgb_p1;
  logic       hsync_p1, vsync_p1;
  logic [9:0] hcount_p1, vcount_p1;

  // Capture colour, syncs and coordinates of the current pixel on each pe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p1    <= 3'b000;
      hsync_p1  <= 1'b1;
      vsync_p1  <= 1'b1;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
    end else if (pe) begin
      rgb_p1    <= active ? (plat_hit ? COLOR_PLAT : COLOR_BG) : 3'b000;
      hsync_p1  <= !((h_p0 >= 10'(HS_START)) && (h_p0 < 10'(HS_END)));
      vsync_p1  <= !((v_p0 >= 10'(VS_START)) && (v_p0 < 10'(VS_END)));
      hcount_p1 <= h_p0;
      vcount_p1 <= v_p0;
    end
  end

  assign rgb    = rgb_p1;
  assign hsync  = hsync_p1;
  assign vsync  = vsync_p1;
  assign hcount = hcount_p1;
  assign vcount = vcount_p1;

endmodule

// File: tb/tb_vga_platform_renderer.sv
// Bench for vga_platform_renderer on a reduced raster so that several
// frames fit in a short run. A reference model derives every output from
// the number of clocks since reset release and a list of hole positions.
module tb_vga_platform_renderer;

  localparam int HA = 48, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VSW = 3, VBP = 3;
  localparam int CD = 2, NP = 4, Y0 = 4, PITCH = 12, PH = 3, HW = 10, STEP = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int BUD = 2 * FRAME * CD;
  localparam logic [2:0] BG = 3'b001, PLAT = 3'b010;

  logic       clk = 1'b0, reset = 1'b0, scroll_en = 1'b0, dir = 1'b0;
  logic [2:0] rgb;
  logic       hsync, vsync, frame_tick;
  logic [9:0] hcount, vcount;

  int checks = 0, errors = 0;
  int n = 0, cyc = 0;
  int m_hole [NP];

  vga_platform_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(CD), .N_PLAT(NP), .PLAT_Y0(Y0), .PLAT_PITCH(PITCH),
    .PLAT_H(PH), .HOLE_W(HW), .HOLE_STEP(STEP),
    .COLOR_BG(BG), .COLOR_PLAT(PLAT)
  ) dut (
    .clk(clk), .reset(reset), .scroll_en(scroll_en), .dir(dir),
    .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame tick is visible after 'edges' clocks when the next clock is a pixel
  // enable and the raster sits on the last pixel of the last active line.
  function automatic logic model_tick(input int edges);
    return ((edges + 1) % CD == 0) && (((edges / CD) % FRAME) == VA * HT - 1);
  endfunction

  function automatic logic [2:0] model_rgb(input int x, input int y);
    if (x >= HA || y >= VA) return 3'b000;
    for (int i = 0; i < NP; i++) begin
      if (y >= Y0 + i * PITCH && y < Y0 + i * PITCH + PH &&
          ((x - m_hole[i] + HA) % HA) >= HW) return PLAT;
    end
    return BG;
  endfunction

  // Reference model state: clocks since release and hole positions.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n <= 0;
      for (int i = 0; i < NP; i++) m_hole[i] <= i * (HA / NP);
    end else begin
      n <= n + 1;
      if (model_tick(n) && scroll_en) begin
        for (int i = 0; i < NP; i++) begin
          if ((i % 2 == 0) != dir) m_hole[i] <= (m_hole[i] + STEP) % HA;
          else                     m_hole[i] <= (m_hole[i] + HA - STEP) % HA;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  int ck_k, ck_p, ck_x, ck_y;
  logic [2:0] e_rgb;
  logic e_hs, e_vs;
  logic [9:0] e_hc, e_vc;
  always @(negedge clk) begin
    ck_k = n / CD;
    if (ck_k == 0) begin
      e_rgb = 3'b000; e_hs = 1'b1; e_vs = 1'b1; e_hc = '0; e_vc = '0;
    end else begin
      ck_p  = (ck_k - 1) % FRAME;
      ck_x  = ck_p % HT;
      ck_y  = ck_p / HT;
      e_rgb = model_rgb(ck_x, ck_y);
      e_hs  = !(ck_x >= HA + HFP && ck_x < HA + HFP + HSW);
      e_vs  = !(ck_y >= VA + VFP && ck_y < VA + VFP + VSW);
      e_hc  = 10'(ck_x);
      e_vc  = 10'(ck_y);
    end
    chk("cyc_rgb", rgb, e_rgb);
    chk("cyc_hsync", hsync, e_hs);
    chk("cyc_vsync", vsync, e_vs);
    chk("cyc_hcount", hcount, e_hc);
    chk("cyc_vcount", vcount, e_vc);
    chk("cyc_frame_tick", frame_tick, model_tick(n));
  end

  task automatic wait_pix(input int x, input int y);
    int t;
    t = 0;
    while (!(int'(hcount) == x && int'(vcount) == y) && t < BUD) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (t < BUD) else begin
      errors++;
      $error("FAIL wait_pix(%0d,%0d): waited %0d cycles, limit %0d", x, y, t, BUD);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [2:0] want);
    wait_pix(x, y);
    chk(tag, rgb, want);
  endtask

  task automatic wait_tick();
    int t;
    t = 0;
    while (frame_tick !== 1'b1 && t < BUD) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (t < BUD) else begin
      errors++;
      $error("FAIL wait_tick: waited %0d cycles, limit %0d", t, BUD);
    end
  endtask

  initial begin
    int lo, per, rel, rtick;
    reset = 1'b0; scroll_en = 1'b0; dir = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_frame_tick", frame_tick, 0);

    reset = 1'b1;
    rel = cyc;

    // Horizontal sync placement, width and period.
    lo = 0;
    while (hsync !== 1'b0 && lo < BUD) begin @(negedge clk); lo++; end
    chk("hsync_first_fall_clks", cyc - rel, CD * (HA + HFP + 1));
    lo = 0;
    while (hsync === 1'b0 && lo < BUD) begin @(negedge clk); lo++; end
    chk("hsync_low_clks", lo, HSW * CD);
    per = lo;
    while (hsync === 1'b1 && per < BUD) begin @(negedge clk); per++; end
    chk("hsync_period_clks", per, HT * CD);

    // Static geometry in frame 1 (holes at 0,12,24,36).
    pix("f1_line3_bg", 10, 3, BG);
    pix("f1_hole0_last", 9, 4, BG);
    pix("f1_plat0", 10, 4, PLAT);
    pix("f1_blank_x", HA, 4, 3'b000);
    pix("f1_plat1_before_hole", 11, 16, PLAT);
    pix("f1_hole1_first", 12, 16, BG);
    pix("f1_hole1_last", 21, 16, BG);
    pix("f1_plat1_after_hole", 22, 16, PLAT);

    wait_tick();
    chk("first_tick_clks", cyc - rel, CD * VA * HT - 1);
    rtick = cyc;
    @(negedge clk);
    scroll_en = 1'b1; dir = 1'b1;

    // Frame 2: tick 1 saw scroll_en=0, holes unchanged.
    pix("f2_hole0_held", 9, 4, BG);
    pix("f2_plat0_held", 10, 4, PLAT);
    wait_tick();
    chk("tick_period_clks", cyc - rtick, CD * FRAME);
    @(negedge clk);
    scroll_en = 1'b0;

    // Frame 3: dir=1 moved holes to 44 (wraps), 16, 20, 40.
    pix("f3_wrap_x0", 0, 4, BG);
    pix("f3_wrap_x5", 5, 4, BG);
    pix("f3_wrap_x6", 6, 4, PLAT);
    pix("f3_wrap_x43", 43, 4, PLAT);
    pix("f3_wrap_x44", 44, 4, BG);
    pix("f3_wrap_x47", 47, 4, BG);
    pix("f3_p1_x15", 15, 16, PLAT);
    pix("f3_p1_x16", 16, 16, BG);
    pix("f3_p1_x25", 25, 16, BG);
    pix("f3_p1_x26", 26, 16, PLAT);
    pix("f3_p2_x19", 19, 28, PLAT);
    pix("f3_p2_x20", 20, 28, BG);
    wait_tick();
    @(negedge clk);

    // Random frames; inputs also change mid-frame and count only at the tick.
    for (int f = 0; f < 4; f++) begin
      scroll_en = ($urandom_range(3) != 0);
      dir = 1'($urandom_range(1));
      lo = 0;
      while (frame_tick !== 1'b1 && lo < BUD) begin
        @(negedge clk);
        lo++;
        if ($urandom_range(299) == 0) begin
          scroll_en = 1'($urandom_range(1));
          dir = 1'($urandom_range(1));
        end
      end
      checks++;
      assert (lo < BUD) else begin
        errors++;
        $error("FAIL random_frame_%0d: no tick after %0d cycles", f, lo);
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a frame.
    scroll_en = 1'b1;
    wait_pix(0, 25);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_hcount", hcount, 0);
    chk("mid_rst_vcount", vcount, 0);
    chk("mid_rst_frame_tick", frame_tick, 0);
    @(negedge clk);
    @(negedge clk);
    scroll_en = 1'b0;
    reset = 1'b1;
    rel = cyc;
    wait_tick();
    chk("tick_after_reset_clks", cyc - rel, CD * VA * HT - 1);
    @(negedge clk);
    pix("post_rst_hole0", 9, 4, BG);
    pix("post_rst_plat0", 10, 4, PLAT);
    pix("post_rst_plat1", 11, 16, PLAT);
    pix("post_rst_hole1", 12, 16, BG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
